// File: rtl/rf_ctx_engine.sv
// Register-file context save/restore engine: streams GPRs FIRST_REG..LAST_REG
// out through a valid/ready source, or writes them back from a valid/ready sink.
module rf_ctx_engine #(
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_RD,
    SAVE_WAIT,
    RESTORE,
    DONE
  } state_t;

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  state_t     state;
  logic [4:0] ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        // save takes priority when both requests arrive together
        IDLE: begin
          if (save_req) begin
            ptr   <= FIRST_A;
            state <= SAVE_RD;
          end else if (restore_req) begin
            ptr   <= FIRST_A;
            state <= RESTORE;
          end
        end
        SAVE_RD: begin
          out_data  <= rf_rdata;
          out_valid <= 1'b1;
          state     <= SAVE_WAIT;
        end
        SAVE_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ptr == LAST_A) begin
              state <= DONE;
            end else begin
              ptr   <= ptr + 5'd1;
              state <= SAVE_RD;
            end
          end
        end
        RESTORE: begin
          if (in_valid) begin
            if (ptr == LAST_A) state <= DONE;
            else               ptr   <= ptr + 5'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded straight from state so an asynchronous reset drops them at once
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign in_ready = (state == RESTORE);
  assign rf_we    = in_ready && in_valid;
  assign rf_wdata = in_ready ? in_data : '0;
  assign rf_raddr = ptr;
  assign rf_waddr = ptr;

endmodule
